// File: rtl/seq_scan_ctrl.sv
// Word-level wrapper around a bit-serial Moore "101" detector: accepts a word, shifts it MSB-first,
// reports a saturating detection count. Define SEQ_SCAN_OVERLAP_EN for fully overlapping detection.
module seq_scan_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  input  logic             count_ready,
  output logic             ser_bit,
  output logic             det_o,
  output logic             busy
);

  localparam int unsigned IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;
  typedef enum logic [1:0] {S0, S1, S2, S3} det_t;

  state_t           state_q, state_d;
  det_t             det_q, det_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Detector transition; the overlap build lets the trailing 1 of a match start the next one.
  function automatic det_t det_next(input det_t s, input logic b);
    det_t n;
    n = S0;
    case (s)
      S0: n = b ? S1 : S0;
      S1: n = b ? S1 : S2;
      S2: n = b ? S3 : S0;
`ifdef SEQ_SCAN_OVERLAP_EN
      S3: n = b ? S1 : S2;
`else
      S3: n = b ? S1 : S0;
`endif
      default: n = S0;
    endcase
    return n;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      det_q   <= S0;
      shreg_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      det_q   <= det_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    det_d       = det_q;
    shreg_d     = shreg_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    word_ready  = 1'b0;
    count_valid = 1'b0;
    busy        = 1'b0;
    ser_bit     = 1'b0;
    det_o       = (det_q == S3);
    count_out   = cnt_q;

    case (state_q)
      IDLE: begin
        word_ready = 1'b1;
        if (word_valid) begin
          shreg_d = word_in;
          idx_d   = '0;
          cnt_d   = '0;
          det_d   = S0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy    = 1'b1;
        ser_bit = shreg_q[WIDTH-1];
        det_d   = det_next(det_q, shreg_q[WIDTH-1]);
        shreg_d = shreg_q << 1;
        idx_d   = idx_q + IDX_W'(1);
        if (det_q == S3 && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        if (idx_q == LAST_IDX) state_d = FLUSH;
      end
      FLUSH: begin
        // The detection produced by the last bit is counted here; serial input idles at 0.
        busy  = 1'b1;
        det_d = det_next(det_q, 1'b0);
        if (det_q == S3 && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        state_d = DONE;
      end
      DONE: begin
        count_valid = 1'b1;
        if (count_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Randomised self-checking bench for seq_scan_ctrl: an 8-bit/4-bit instance and a 16-bit/2-bit
// saturation instance, both checked against a pattern-counting reference model.
module tb_seq_scan_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  a_word_in;
  logic        a_word_valid, a_word_ready, a_count_valid, a_count_ready;
  logic [3:0]  a_count_out;
  logic        a_ser_bit, a_det_o, a_busy;
  logic [15:0] b_word_in;
  logic        b_word_valid, b_word_ready, b_count_valid, b_count_ready;
  logic [1:0]  b_count_out;
  logic        b_ser_bit, b_det_o, b_busy;

  int total = 0;
  int bad   = 0;

`ifdef SEQ_SCAN_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  always #5 clock = ~clock;

  seq_scan_ctrl #(.WIDTH(8), .CNT_W(4)) dut_a (
    .clock(clock), .reset(reset), .word_in(a_word_in), .word_valid(a_word_valid),
    .word_ready(a_word_ready), .count_out(a_count_out), .count_valid(a_count_valid),
    .count_ready(a_count_ready), .ser_bit(a_ser_bit), .det_o(a_det_o), .busy(a_busy));

  seq_scan_ctrl #(.WIDTH(16), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .word_in(b_word_in), .word_valid(b_word_valid),
    .word_ready(b_word_ready), .count_out(b_count_out), .count_valid(b_count_valid),
    .count_ready(b_count_ready), .ser_bit(b_ser_bit), .det_o(b_det_o), .busy(b_busy));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: leftmost-first "101" matches in MSB-first order; without overlap a match may not
  // reuse any bit of the previous one, with overlap it may reuse the trailing 1.
  function automatic int model_count(input logic [15:0] w, input int width);
    int n = 0;
    int next = 0;
    for (int i = 0; i + 2 < width; i++) begin
      if (i >= next && w[width-1-i] && !w[width-2-i] && w[width-3-i]) begin
        n++;
        next = OVL ? i + 2 : i + 3;
      end
    end
    return n;
  endfunction

  task automatic run_a(input logic [7:0] w, output int lat, output int pulses,
                       output logic [7:0] cap, output int rdy_bad, output logic [3:0] cnt);
    lat = 0; pulses = 0; cap = '0; rdy_bad = 0;
    a_word_in = w; a_word_valid = 1'b1;
    tick();
    a_word_valid = 1'b0;
    while (!a_count_valid && lat < 40) begin
      if (lat < 8) cap = {cap[6:0], a_ser_bit};
      pulses += int'(a_det_o);
      if (a_word_ready) rdy_bad++;
      tick();
      lat++;
    end
    if (!a_count_valid) lat = -1;
    cnt = a_count_out;
    a_count_ready = 1'b1;
    tick();
    a_count_ready = 1'b0;
  endtask

  task automatic run_b(input logic [15:0] w, output int lat, output logic [1:0] cnt);
    lat = 0;
    b_word_in = w; b_word_valid = 1'b1;
    tick();
    b_word_valid = 1'b0;
    while (!b_count_valid && lat < 60) begin
      tick();
      lat++;
    end
    if (!b_count_valid) lat = -1;
    cnt = b_count_out;
    b_count_ready = 1'b1;
    tick();
    b_count_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    total++;
    if ({a_word_ready, a_count_valid, a_count_out, a_ser_bit, a_det_o, a_busy} !== 9'b1_0_0000_0_0_0) begin
      bad++;
      $display("FAIL reset_state: got rdy=%b cv=%b cnt=%0d ser=%b det=%b busy=%b, want 1 0 0 0 0 0",
               a_word_ready, a_count_valid, a_count_out, a_ser_bit, a_det_o, a_busy);
    end
    total++;
    if ({b_word_ready, b_count_valid, b_count_out, b_busy} !== 5'b1_0_00_0) begin
      bad++;
      $display("FAIL reset_state_b: got rdy=%b cv=%b cnt=%0d busy=%b, want 1 0 0 0",
               b_word_ready, b_count_valid, b_count_out, b_busy);
    end
  endtask

  task automatic check_word_a(input string name, input logic [7:0] w);
    int lat, pulses, rdy_bad, exp;
    logic [7:0] cap;
    logic [3:0] cnt;
    exp = model_count({8'h00, w}, 8);
    run_a(w, lat, pulses, cap, rdy_bad, cnt);
    total++;
    if (lat != 9 || cnt !== 4'(exp) || pulses != exp || cap !== w || rdy_bad != 0) begin
      bad++;
      $display("FAIL %s w=%b: got lat=%0d cnt=%0d pulses=%0d ser=%b rdybad=%0d, want lat=9 cnt=%0d pulses=%0d ser=%b rdybad=0",
               name, w, lat, cnt, pulses, cap, rdy_bad, exp, exp, w);
    end
    total++;
    if (a_word_ready !== 1'b1 || a_count_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_return_idle: got rdy=%b cv=%b, want 1 0", name, a_word_ready, a_count_valid);
    end
  endtask

  task automatic test_directed();
    check_word_a("word_10110100", 8'b10110100);
    check_word_a("word_ff", 8'hFF);
    check_word_a("word_00", 8'h00);
    check_word_a("word_10101010", 8'b10101010);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) check_word_a("random_a", 8'($urandom));
  endtask

  task automatic test_saturation();
    int lat, exp;
    logic [1:0] cnt;
    logic [15:0] w;
    run_b(16'b1011011011011011, lat, cnt);
    total++;
    if (lat != 17 || cnt !== 2'd3) begin
      bad++;
      $display("FAIL saturate_16: got lat=%0d cnt=%0d, want lat=17 cnt=3", lat, cnt);
    end
    for (int i = 0; i < 10; i++) begin
      w = 16'($urandom);
      exp = model_count(w, 16);
      if (exp > 3) exp = 3;
      run_b(w, lat, cnt);
      total++;
      if (lat != 17 || cnt !== 2'(exp)) begin
        bad++;
        $display("FAIL random_b w=%b: got lat=%0d cnt=%0d, want lat=17 cnt=%0d", w, lat, cnt, exp);
      end
    end
  endtask

  task automatic test_hold_done();
    int lat = 0;
    int hold_bad = 0;
    a_word_in = 8'b10110100; a_word_valid = 1'b1;
    tick();
    a_word_valid = 1'b0;
    while (!a_count_valid && lat < 40) begin
      tick();
      lat++;
    end
    total++;
    if (lat != 9) begin
      bad++;
      $display("FAIL hold_latency: got %0d, want 9", lat);
    end
    for (int i = 0; i < 5; i++) begin
      a_word_valid = ~a_word_valid;
      a_word_in = 8'($urandom);
      a_count_ready = 1'b0;
      tick();
      if (a_count_out !== 4'd2 || a_count_valid !== 1'b1 || a_word_ready !== 1'b0) hold_bad++;
    end
    total++;
    if (hold_bad != 0) begin
      bad++;
      $display("FAIL hold_stable: got %0d unstable cycles (last cnt=%0d cv=%b), want 0 (cnt=2 cv=1)",
               hold_bad, a_count_out, a_count_valid);
    end
    a_word_valid = 1'b0;
    a_count_ready = 1'b1;
    tick();
    a_count_ready = 1'b0;
    total++;
    if (a_word_ready !== 1'b1 || a_count_valid !== 1'b0 || a_busy !== 1'b0) begin
      bad++;
      $display("FAIL hold_release: got rdy=%b cv=%b busy=%b, want 1 0 0", a_word_ready, a_count_valid, a_busy);
    end
    tick();
    total++;
    if (a_busy !== 1'b0 || a_word_ready !== 1'b1) begin
      bad++;
      $display("FAIL hold_no_capture: got busy=%b rdy=%b, want 0 1", a_busy, a_word_ready);
    end
  endtask

  task automatic test_reset_mid_word();
    int cv_seen = 0;
    a_word_in = 8'b10110100; a_word_valid = 1'b1;
    tick();
    a_word_valid = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({a_word_ready, a_count_out, a_det_o, a_ser_bit, a_busy, a_count_valid} !== 9'b1_0000_0_0_0_0) begin
      bad++;
      $display("FAIL reset_mid: got rdy=%b cnt=%0d det=%b ser=%b busy=%b cv=%b, want 1 0 0 0 0 0",
               a_word_ready, a_count_out, a_det_o, a_ser_bit, a_busy, a_count_valid);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (a_count_valid || a_busy) cv_seen++;
    end
    total++;
    if (cv_seen != 0) begin
      bad++;
      $display("FAIL reset_mid_no_report: got %0d active cycles, want 0", cv_seen);
    end
    check_word_a("after_reset", 8'b10100101);
  endtask

  initial begin
    reset = 1'b1;
    a_word_in = '0; a_word_valid = 1'b0; a_count_ready = 1'b0;
    b_word_in = '0; b_word_valid = 1'b0; b_count_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_saturation();
    test_hold_done();
    test_reset_mid_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
